// File: rtl/usb_rx_ctrl.sv
// Transaction controller for the USB receive path: sequences OUT and IN transactions,
// gates rx buffer writes and requests handshakes. Optional bus-turnaround timeout: USB_RX_CTRL_TIMEOUT_EN.
module usb_rx_ctrl #(
    parameter int MAX_BYTES      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rx_packet,
    input  logic       store_rx_packet,
    input  logic       data_loaded,
    input  logic       packet_done,
    input  logic       r_error,
    input  logic       tx_done,
    input  logic       tx_data_avail,
    input  logic       rx_data_consumed,
    input  logic       err_clear,
    output logic [1:0] tx_packet,
    output logic       tx_start,
    output logic       rx_buf_wr_en,
    output logic       rx_flush,
    output logic       rx_data_ready,
    output logic       rx_error_flag,
    output logic       tx_transfer_done,
    output logic       rx_transfer_active,
    output logic [6:0] byte_count
);

    localparam logic [2:0] PID_OUT  = 3'd1;
    localparam logic [2:0] PID_IN   = 3'd2;
    localparam logic [2:0] PID_DATA = 3'd3;
    localparam logic [2:0] PID_ACK  = 3'd4;

    localparam logic [1:0] TX_NONE = 2'd0;
    localparam logic [1:0] TX_ACK  = 2'd1;
    localparam logic [1:0] TX_NAK  = 2'd2;
    localparam logic [1:0] TX_DATA = 2'd3;

    localparam logic [6:0] BC_MAX = 7'(MAX_BYTES);
    localparam logic [6:0] BC_SAT = 7'(MAX_BYTES + 1);

    // byte_count must hold MAX_BYTES+1 in 7 bits
    if (MAX_BYTES < 1 || MAX_BYTES > 126 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("usb_rx_ctrl: MAX_BYTES or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        OUT_WAIT_DATA,
        OUT_DATA,
        SEND_HS,
        IN_SEND,
        IN_WAIT_ACK
    } state_t;

    state_t     state, state_nxt;
    logic       accept, accept_nxt;
    logic [1:0] tx_packet_nxt;
    logic       tx_start_nxt;
    logic       wr_en_nxt;
    logic       flush_nxt;
    logic       ready_nxt;
    logic       err_nxt;
    logic       done_nxt;
    logic [6:0] count_nxt;
    logic [6:0] count_inc;
    logic       set_ready;
    logic       set_err;

    function automatic logic [6:0] sat_inc(input logic [6:0] c);
        return (c >= BC_SAT) ? BC_SAT : c + 7'd1;
    endfunction

`ifdef USB_RX_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_nxt != state) begin
            tmo_cnt <= '0;
        end else if (state == OUT_WAIT_DATA || state == IN_WAIT_ACK) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_nxt     = state;
        accept_nxt    = accept;
        tx_packet_nxt = tx_packet;
        tx_start_nxt  = 1'b0;
        wr_en_nxt     = rx_buf_wr_en;
        flush_nxt     = 1'b0;
        done_nxt      = 1'b0;
        count_nxt     = byte_count;
        set_ready     = 1'b0;
        set_err       = 1'b0;
        // a byte arriving with EOP is counted before the overflow check
        count_inc     = data_loaded ? sat_inc(byte_count) : byte_count;

        case (state)
            IDLE: begin
                if (store_rx_packet) begin
                    if (rx_packet == PID_OUT) begin
                        accept_nxt = !rx_data_ready;
                        state_nxt  = OUT_WAIT_DATA;
                    end else if (rx_packet == PID_IN) begin
                        tx_packet_nxt = tx_data_avail ? TX_DATA : TX_NAK;
                        tx_start_nxt  = 1'b1;
                        state_nxt     = IN_SEND;
                    end
                end
            end
            OUT_WAIT_DATA: begin
                if (store_rx_packet) begin
                    if (rx_packet == PID_DATA) begin
                        count_nxt = 7'd0;
                        wr_en_nxt = accept;
                        state_nxt = OUT_DATA;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
`ifdef USB_RX_CTRL_TIMEOUT_EN
                else if (tmo_hit) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            OUT_DATA: begin
                wr_en_nxt = accept;
                count_nxt = count_inc;
                if (packet_done) begin
                    wr_en_nxt = 1'b0;
                    if (r_error) begin
                        flush_nxt = 1'b1;
                        set_err   = 1'b1;
                        state_nxt = IDLE;
                    end else if (!accept || count_inc > BC_MAX) begin
                        tx_packet_nxt = TX_NAK;
                        tx_start_nxt  = 1'b1;
                        flush_nxt     = 1'b1;
                        set_err       = (count_inc > BC_MAX);
                        state_nxt     = SEND_HS;
                    end else begin
                        tx_packet_nxt = TX_ACK;
                        tx_start_nxt  = 1'b1;
                        set_ready     = 1'b1;
                        state_nxt     = SEND_HS;
                    end
                end
            end
            SEND_HS: begin
                if (tx_done) begin
                    tx_packet_nxt = TX_NONE;
                    state_nxt     = IDLE;
                end
            end
            IN_SEND: begin
                if (tx_done) begin
                    tx_packet_nxt = TX_NONE;
                    state_nxt     = (tx_packet == TX_DATA) ? IN_WAIT_ACK : IDLE;
                end
            end
            IN_WAIT_ACK: begin
                if (store_rx_packet) begin
                    done_nxt  = (rx_packet == PID_ACK);
                    state_nxt = IDLE;
                end
`ifdef USB_RX_CTRL_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // new events take priority over host clear strobes
        ready_nxt = set_ready | (rx_data_ready & !rx_data_consumed);
        err_nxt   = set_err | (rx_error_flag & !err_clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            accept             <= 1'b0;
            tx_packet          <= TX_NONE;
            tx_start           <= 1'b0;
            rx_buf_wr_en       <= 1'b0;
            rx_flush           <= 1'b0;
            rx_data_ready      <= 1'b0;
            rx_error_flag      <= 1'b0;
            tx_transfer_done   <= 1'b0;
            rx_transfer_active <= 1'b0;
            byte_count         <= 7'd0;
        end else begin
            state              <= state_nxt;
            accept             <= accept_nxt;
            tx_packet          <= tx_packet_nxt;
            tx_start           <= tx_start_nxt;
            rx_buf_wr_en       <= wr_en_nxt;
            rx_flush           <= flush_nxt;
            rx_data_ready      <= ready_nxt;
            rx_error_flag      <= err_nxt;
            tx_transfer_done   <= done_nxt;
            rx_transfer_active <= (state_nxt == OUT_WAIT_DATA) || (state_nxt == OUT_DATA);
            byte_count         <= count_nxt;
        end
    end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Transaction-level controller for the USB receive datapath in the Lab12 endpoint. Sits between `usb_rx` (decoded PID, byte strobes, EOP, error) and the transmit/host side. Sequences OUT transactions (token -> data -> handshake) and IN transactions (token -> data or NAK -> host ACK). Gates rx buffer writes, counts received bytes, requests ACK/NAK/DATA from the transmitter and raises status flags for the host interface.

## Interface
Parameters:
- MAX_BYTES, 64, largest accepted data payload in bytes
- TIMEOUT_CYCLES, 1024, bus-turnaround limit in clk cycles; only used with the timeout feature

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rx_packet  in  3  decoded PID: 1 OUT, 2 IN, 3 DATA, 4 ACK, 5 NAK, others invalid
- store_rx_packet  in  1  one-cycle strobe, rx_packet valid
- data_loaded  in  1  one-cycle strobe per payload byte written to rx buffer
- packet_done  in  1  one-cycle strobe at EOP
- r_error  in  1  datapath error (sync/CRC/format), valid with packet_done
- tx_done  in  1  one-cycle strobe, transmitter finished current packet
- tx_data_avail  in  1  host has IN data staged
- rx_data_consumed  in  1  host strobe: received data read, clears rx_data_ready
- err_clear  in  1  host strobe, clears rx_error_flag
- tx_packet  out  2  requested TX packet: 0 none, 1 ACK, 2 NAK, 3 DATA
- tx_start  out  1  one-cycle TX request strobe
- rx_buf_wr_en  out  1  rx buffer write gate
- rx_flush  out  1  one-cycle strobe, discard current rx buffer contents
- rx_data_ready  out  1  valid OUT payload held for host
- rx_error_flag  out  1  sticky error
- tx_transfer_done  out  1  one-cycle strobe, IN data acknowledged by host
- rx_transfer_active  out  1  high in OUT_WAIT_DATA and OUT_DATA
- byte_count  out  7  bytes in last/current OUT payload

## Operation
- States: IDLE, OUT_WAIT_DATA, OUT_DATA, SEND_HS, IN_SEND, IN_WAIT_ACK.
- IDLE, store_rx_packet & OUT:
  - latch accept = !rx_data_ready
  - go to OUT_WAIT_DATA
- IDLE, store_rx_packet & IN:
  - tx_packet = DATA if tx_data_avail, else NAK
  - pulse tx_start
  - go to IN_SEND
- IDLE, other PIDs: ignored.
- OUT_WAIT_DATA:
  - DATA PID: byte_count = 0, go to OUT_DATA
  - any other PID: set rx_error_flag, go to IDLE
- OUT_DATA:
  - rx_buf_wr_en = accept.
  - Each data_loaded increments byte_count, saturating at MAX_BYTES+1.
  - On packet_done:
    - r_error: rx_flush, set error, go to IDLE with no handshake
    - else !accept or byte_count > MAX_BYTES: NAK, rx_flush (overflow also sets error)
    - else ACK, set rx_data_ready
  - Handshake cases go to SEND_HS with a tx_start pulse.
- SEND_HS: tx_done -> IDLE, tx_packet returns to 0.
- IN_SEND: tx_done -> IN_WAIT_ACK if DATA was sent, else IDLE.
- IN_WAIT_ACK:
  - ACK PID: pulse tx_transfer_done, go to IDLE
  - any other PID: IDLE, no done (host retries)
- rx_data_consumed clears rx_data_ready.

## Timing
- All outputs registered.
- Reset: state IDLE, all outputs 0, accept 0, timeout counter 0. Reset mid-transaction aborts with no handshake and no strobes.
- tx_start is asserted the cycle after the deciding strobe (store_rx_packet or packet_done).
- tx_packet is valid with tx_start and held until the tx_done cycle.
- rx_buf_wr_en changes the cycle after the DATA PID strobe, and drops the cycle after packet_done.
- data_loaded and packet_done in the same cycle: the byte is counted before the overflow check.
- rx_data_consumed in the same cycle as an ACK-path set: the set wins.
- err_clear in the same cycle as a new error: the error wins.
- store_rx_packet in SEND_HS or IN_SEND: ignored.

## Configuration
- USB_RX_CTRL_TIMEOUT_EN defined:
  - a counter runs in OUT_WAIT_DATA and IN_WAIT_ACK
  - reaching TIMEOUT_CYCLES returns to IDLE
  - OUT_WAIT_DATA timeout also sets rx_error_flag
  - the counter clears on every state change
- Undefined: both states wait indefinitely; no counter logic is present.

## Test plan
- OUT, DATA, 8 data_loaded, clean packet_done -> rx_buf_wr_en high for the payload; tx_packet=1 with tx_start one cycle later; byte_count=8; rx_data_ready=1 after tx_done.
- Repeat OUT+DATA without rx_data_consumed -> rx_buf_wr_en stays 0; NAK (tx_packet=2); rx_flush pulse; byte_count reflects the new packet; rx_data_ready stays 1.
- OUT, DATA, 65 bytes with MAX_BYTES=64 -> byte_count=65; NAK; rx_flush; rx_error_flag=1; err_clear -> 0.
- OUT, DATA, packet_done with r_error=1 -> no tx_start; rx_flush pulse; rx_error_flag=1; state returns to IDLE.
- IN with tx_data_avail=1, tx_done, then ACK -> tx_packet=3; tx_transfer_done pulses once. IN with tx_data_avail=0 -> tx_packet=2, no done pulse.
- With USB_RX_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: OUT with no DATA for 16 cycles -> IDLE, rx_error_flag=1. Assert rst mid-OUT_DATA -> all outputs 0 immediately.
